painterengine_gpu_write_stager: RTL

- Per-channel staging FIFO placed directly upstream of the GPU DMA writer. One instance drives one channel's data word, valid bit and next bit into the writer.
- Accepts a job length, takes exactly that many 32-bit pixel words from a render producer, and buffers them.
- Presents the head word show-ahead so the writer can pop it on its data-next strobe.
- Signals done once every word of the job has been consumed by the writer.

---
 rtl/painterengine_gpu_write_stager.sv | 81 ++++++++
 1 files changed

// File: rtl/painterengine_gpu_write_stager.sv
// painterengine_gpu_write_stager: job-length staging FIFO with show-ahead head word feeding one GPU DMA writer channel.
// Optional misuse detection (ERROR state, sticky o_wire_error) is built when PAINTERENGINE_GPU_STAGER_ERRCHECK_EN is defined.
module painterengine_gpu_write_stager #(
  parameter int PARAM_DEPTH_LOG2 = 4,
  parameter int PARAM_DATA_WIDTH = 32
) (
  input  logic                        i_wire_clock,
  input  logic                        i_wire_reset,
  input  logic                        i_wire_start,
  input  logic [31:0]                 i_wire_length,
  input  logic [PARAM_DATA_WIDTH-1:0] i_wire_in_data,
  input  logic                        i_wire_in_valid,
  output logic                        o_wire_in_ready,
  output logic [PARAM_DATA_WIDTH-1:0] o_wire_data,
  output logic                        o_wire_data_valid,
  input  logic                        i_wire_data_next,
  output logic                        o_wire_busy,
  output logic                        o_wire_done,
  output logic                        o_wire_error
);
  localparam int DEPTH = 1 << PARAM_DEPTH_LOG2;
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_DRAIN, S_DONE, S_ERROR} state_t;
  state_t state_q, state_d;
  logic [PARAM_DEPTH_LOG2-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [PARAM_DEPTH_LOG2:0] count_q, count_d;
  logic [31:0] in_rem_q, in_rem_d, out_rem_q, out_rem_d;
  logic [PARAM_DATA_WIDTH-1:0] mem_q [DEPTH];
  logic busy, push, pop, launch;
  // count MSB is set only at exactly DEPTH words, so it doubles as the full flag
  always_comb begin
    busy = state_q == S_FILL || state_q == S_DRAIN;
    o_wire_in_ready = state_q == S_FILL && !count_q[PARAM_DEPTH_LOG2] && in_rem_q != 0;
    o_wire_data_valid = busy && count_q != 0;
    o_wire_data = o_wire_data_valid ? mem_q[rd_q] : '0;
    o_wire_busy = busy;
    o_wire_done = state_q == S_DONE;
`ifdef PAINTERENGINE_GPU_STAGER_ERRCHECK_EN
    o_wire_error = state_q == S_ERROR;
`else
    o_wire_error = 1'b0;
`endif
    push = i_wire_in_valid && o_wire_in_ready;
    pop = i_wire_data_next && o_wire_data_valid;
    launch = i_wire_start && (state_q == S_IDLE || state_q == S_DONE);
    wr_d = push ? wr_q + 1'b1 : wr_q;
    rd_d = pop ? rd_q + 1'b1 : rd_q;
    count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    in_rem_d = launch ? i_wire_length : in_rem_q - {31'b0, push};
    out_rem_d = launch ? i_wire_length : out_rem_q - {31'b0, pop};
    state_d = state_q;
    if (launch)
      state_d = i_wire_length == 0 ? S_DONE : S_FILL;
    else if (busy)
      state_d = out_rem_d == 0 ? S_DONE : in_rem_d == 0 ? S_DRAIN : S_FILL;
`ifdef PAINTERENGINE_GPU_STAGER_ERRCHECK_EN
    if (busy && (i_wire_start || (i_wire_data_next && !o_wire_data_valid)))
      state_d = S_ERROR;
`endif
  end
  always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
    if (i_wire_reset) begin
      state_q <= S_IDLE;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      in_rem_q <= '0;
      out_rem_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      in_rem_q <= in_rem_d;
      out_rem_q <= out_rem_d;
    end
  end
  // storage needs no reset: the head is masked to zero whenever it is not valid
  always_ff @(posedge i_wire_clock) begin
    if (push) mem_q[wr_q] <= i_wire_in_data;
  end
endmodule
